// File: rtl/uart_byte_fifo_pkg.sv
// Shared definitions for the UART-to-shift-driver byte FIFO: pop FSM states and widths.
package uart_byte_fifo_pkg;

    localparam int BYTE_W = 8;
    localparam int GAP_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/fifo_mem_sync.sv
// Single-clock byte storage: one write port, one registered read port with read enable.
module fifo_mem_sync #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register only loads on a pop, so the popped byte is held between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/uart_byte_fifo.sv
// Byte FIFO between UART receiver and 74HC595 shift driver, pacing pops as spaced one-cycle strobes.
// Optional macro UART_BYTE_FIFO_LEVEL_EN adds the level and almost_full outputs.
module uart_byte_fifo
    import uart_byte_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int MIN_GAP    = 2
`ifdef UART_BYTE_FIFO_LEVEL_EN
    ,
    parameter int ALMOST_FULL = (2 ** DEPTH_LOG2) - 2
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              sink_busy,
    output logic              out_strobe,
    output logic [BYTE_W-1:0] out_data,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              overflow_clr
`ifdef UART_BYTE_FIFO_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0] level,
    output logic                almost_full
`endif
);

    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    fifo_state_t             state_reg, state_next;
    logic [GAP_W-1:0]        gap_reg, gap_next;
    logic [DEPTH_LOG2-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [DEPTH_LOG2:0]     count_reg, count_next;
    logic                    full_reg, empty_reg, overflow_reg, strobe_reg;
    logic                    push, pop, drop, rd_en;

    // A pop in the ISSUE cycle frees a slot, so a push into a full FIFO is accepted then.
    assign pop  = (state_reg == ST_ISSUE);
    assign push = in_valid && (!full_reg || pop);
    assign drop = in_valid && full_reg && !pop;

    always_comb begin
        state_next = state_reg;
        gap_next   = gap_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!empty_reg && !sink_busy) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_GAP;
                gap_next   = GAP_W'(MIN_GAP - 1);
            end
            ST_GAP: begin
                if (gap_reg != '0) begin
                    gap_next = gap_reg - GAP_W'(1);
                end else if (!sink_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rd_en = (state_reg == ST_IDLE) && (state_next == ST_ISSUE);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_next = count_reg - (DEPTH_LOG2 + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            gap_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
            strobe_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            gap_reg    <= gap_next;
            count_reg  <= count_next;
            full_reg   <= (count_next == FULL_CNT);
            empty_reg  <= (count_next == '0);
            strobe_reg <= (state_next == ST_ISSUE);
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
            end
            // A dropped byte outranks a simultaneous clear.
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (overflow_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    fifo_mem_sync #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (BYTE_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_reg),
        .rd_data (out_data)
    );

    assign out_strobe = strobe_reg;
    assign full       = full_reg;
    assign empty      = empty_reg;
    assign overflow   = overflow_reg;

`ifdef UART_BYTE_FIFO_LEVEL_EN
    logic [DEPTH_LOG2:0] level_reg;
    logic                almost_full_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg       <= '0;
            almost_full_reg <= 1'b0;
        end else begin
            level_reg       <= count_next;
            almost_full_reg <= (count_next >= (DEPTH_LOG2 + 1)'(ALMOST_FULL));
        end
    end

    assign level       = level_reg;
    assign almost_full = almost_full_reg;
`endif

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Scoreboard bench for uart_byte_fifo: accepted pushes are queued, every strobe pops and compares.
module tb_uart_byte_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int MIN_GAP    = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       sink_busy;
    logic       out_strobe;
    logic [7:0] out_data;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       overflow_clr;
`ifdef UART_BYTE_FIFO_LEVEL_EN
    logic [DEPTH_LOG2:0] level;
    logic                almost_full;
`endif

    logic hold_busy = 1'b0;
    logic auto_busy = 1'b0;
    assign sink_busy = hold_busy | auto_busy;

    uart_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .MIN_GAP    (MIN_GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .sink_busy    (sink_busy),
        .out_strobe   (out_strobe),
        .out_data     (out_data),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
`ifdef UART_BYTE_FIFO_LEVEL_EN
        ,
        .level        (level),
        .almost_full  (almost_full)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int   m_cnt       = 0;
    logic m_ov        = 1'b0;
    int   n_strobe    = 0;
    int   last_strobe = -1000;
    int   min_space   = MIN_GAP + 2;
    int   busy_left   = 0;
    logic auto_mode   = 1'b0;
    logic [7:0] last_pop = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: flags against the model, strobes against the scoreboard, then model update.
    initial begin
        logic [7:0] e;
        logic       pop_now;
        logic       accept;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_cnt     = 0;
                m_ov      = 1'b0;
                busy_left = 0;
                auto_busy = 1'b0;
                continue;
            end
            check_eq("empty", empty, (m_cnt == 0));
            check_eq("full", full, (m_cnt == DEPTH));
            check_eq("overflow", overflow, m_ov);
            pop_now = out_strobe;
            accept  = (m_cnt < DEPTH) || pop_now;
            if (pop_now) begin
                n_strobe++;
                $display("pop  data=%02h cycle=%0d", out_data, cyc);
                check_eq("strobe_while_busy", sink_busy, 1'b0);
                check_eq("strobe_spacing", ((cyc - last_strobe) >= min_space), 1'b1);
                last_strobe = cyc;
                check_eq("pop_available", (exp_q.size() > 0), 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("pop_data", out_data, e);
                    m_cnt--;
                end
                last_pop = out_data;
                if (auto_mode) busy_left = 3;
            end
            if (in_valid) begin
                if (accept) begin
                    exp_q.push_back(in_data);
                    m_cnt++;
                    $display("push data=%02h cycle=%0d", in_data, cyc);
                end else begin
                    $display("drop data=%02h cycle=%0d", in_data, cyc);
                end
            end
            if (in_valid && !accept) m_ov = 1'b1;
            else if (overflow_clr)   m_ov = 1'b0;
            if (busy_left > 0) begin
                auto_busy = 1'b1;
                busy_left--;
            end else begin
                auto_busy = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        check_eq("drain_timeout", exp_q.size(), 0);
        tick(MIN_GAP + 6);
    endtask

    initial begin
        int s0;
        int lat;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        overflow_clr = 1'b0;
        tick(3);
        check_eq("rst_empty", empty, 1'b1);
        check_eq("rst_full", full, 1'b0);
        check_eq("rst_overflow", overflow, 1'b0);
        check_eq("rst_strobe", out_strobe, 1'b0);
        check_eq("rst_data", out_data, 8'h00);
        rst_n = 1'b1;
        tick(2);

        // 1: single byte, two-cycle latency
        s0 = n_strobe;
        push(8'hA5);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (out_strobe) begin
                lat = k;
                break;
            end
        end
        check_eq("t1_latency", lat, 2);
        check_eq("t1_data", out_data, 8'hA5);
        tick(8);
        check_eq("t1_strobes", n_strobe - s0, 1);
        check_eq("t1_empty", empty, 1'b1);
        check_eq("t1_hold", out_data, 8'hA5);

        // 2: burst with sink busy 3 cycles after each strobe
        auto_mode = 1'b1;
        min_space = 5;
        s0 = n_strobe;
        for (int i = 1; i <= 5; i++) push(8'(i));
        wait_drain();
        check_eq("t2_strobes", n_strobe - s0, 5);
        check_eq("t2_last", last_pop, 8'h05);
        auto_mode = 1'b0;
        min_space = MIN_GAP + 2;
        tick(4);

        // 3: fill and overflow
        hold_busy = 1'b1;
        for (int i = 1; i <= 16; i++) push(8'(i));
        check_eq("t3_full16", full, 1'b1);
        check_eq("t3_noovf16", overflow, 1'b0);
        push(8'd17);
        check_eq("t3_ovf17", overflow, 1'b1);
        s0 = n_strobe;
        hold_busy = 1'b0;
        wait_drain();
        check_eq("t3_strobes", n_strobe - s0, 16);
        check_eq("t3_last", last_pop, 8'd16);

        // 4a: clear overflow
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        check_eq("t4_cleared", overflow, 1'b0);

        // 5: fill, set-wins on clear, push alongside a strobe while full
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
        check_eq("t5_full", full, 1'b1);
        overflow_clr = 1'b1;
        push(8'h77);
        overflow_clr = 1'b0;
        check_eq("t4_set_wins", overflow, 1'b1);
        s0 = n_strobe;
        hold_busy = 1'b0;
        tick(1);
        check_eq("t5_strobe_now", out_strobe, 1'b1);
        push(8'hEE);
        check_eq("t5_still_full", full, 1'b1);
        wait_drain();
        check_eq("t5_strobes", n_strobe - s0, 17);
        check_eq("t5_last", last_pop, 8'hEE);

        // 6: reset during a strobe with bytes queued
        hold_busy = 1'b1;
        push(8'h61);
        push(8'h62);
        push(8'h63);
        hold_busy = 1'b0;
        tick(1);
        check_eq("t6_strobe_before", out_strobe, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_empty", empty, 1'b1);
        check_eq("t6_strobe", out_strobe, 1'b0);
        check_eq("t6_data", out_data, 8'h00);
        check_eq("t6_overflow", overflow, 1'b0);
        tick(2);
        rst_n = 1'b1;
        s0 = n_strobe;
        tick(20);
        check_eq("t6_no_stale", n_strobe - s0, 0);
        check_eq("t6_empty_after", empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
